// File: rtl/hamming_scrubber.sv
// Background ECC scrubber for a memory of Hamming(7,4) codewords.
// Sweeps addresses 0..DEPTH-1: read, compute syndrome, write back the
// corrected codeword on a single-bit error, then move to the next address.
// Optional feature macro: HAMMING_SECDED_EN (adds overall parity bit p0,
// 8-bit memory data and an uncorrectable-error counter uncorr_cnt).
`timescale 1ns/1ps
module hamming_scrubber #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
`ifdef HAMMING_SECDED_EN
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
`else
  output logic [6:0]        mem_wdata,
  input  logic [6:0]        mem_rdata,
`endif
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  corr_cnt,
`ifdef HAMMING_SECDED_EN
  output logic [CNT_W-1:0]  uncorr_cnt,
`endif
  output logic [ADDR_W-1:0] last_err_addr,
  output logic [2:0]        last_err_pos
);

`ifdef HAMMING_SECDED_EN
  localparam int CW = 8;
`else
  localparam int CW = 7;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, RD, CHK, WR, NEXT, FIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   rdata_p0;
  logic [2:0]      syn;
  logic [6:0]      fixed;
  logic            do_fix;
  logic            do_uncorr;
  logic [CW-1:0]   wfix;

  // Even-parity syndrome; bit i-1 of cw holds codeword position i.
  function automatic logic [2:0] syndrome(input logic [6:0] cw);
    logic s1, s2, s4;
    s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    s4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    return {s4, s2, s1};
  endfunction

  // Invert the codeword bit at position pos (1..7); pos 0 leaves it intact.
  function automatic logic [6:0] flip_pos(input logic [6:0] cw, input logic [2:0] pos);
    logic [6:0] mask;
    mask = '0;
    if (pos != 3'd0) mask[pos - 3'd1] = 1'b1;
    return cw ^ mask;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Decode the captured read word into a correction decision.
  always_comb begin
    syn       = syndrome(rdata_p0[6:0]);
    fixed     = flip_pos(rdata_p0[6:0], syn);
`ifdef HAMMING_SECDED_EN
    do_fix    = ^rdata_p0;
    do_uncorr = (syn != 3'd0) && !(^rdata_p0);
    wfix      = {^fixed, fixed};
`else
    do_fix    = (syn != 3'd0);
    do_uncorr = 1'b0;
    wfix      = fixed;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RD;
      RD:      if (mem_ack) state_d = CHK;
      CHK:     state_d = do_fix ? WR : NEXT;
      WR:      if (mem_ack) state_d = NEXT;
      NEXT:    state_d = (abort || mem_addr == LAST_ADDR) ? FIN : RD;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs, address walk and error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      corr_cnt      <= '0;
`ifdef HAMMING_SECDED_EN
      uncorr_cnt    <= '0;
`endif
      last_err_addr <= '0;
      last_err_pos  <= '0;
    end else begin
      mem_req <= (state_d == RD) || (state_d == WR);
      mem_we  <= (state_d == WR);
      busy    <= (state_d == RD) || (state_d == CHK) || (state_d == WR) || (state_d == NEXT);
      done    <= (state_d == FIN);
      case (state_q)
        IDLE: begin
          if (start) begin
            mem_addr      <= '0;
            corr_cnt      <= '0;
`ifdef HAMMING_SECDED_EN
            uncorr_cnt    <= '0;
`endif
            last_err_addr <= '0;
            last_err_pos  <= '0;
          end
        end
        CHK: begin
          if (do_fix) begin
            mem_wdata     <= wfix;
            corr_cnt      <= sat_inc(corr_cnt);
            last_err_addr <= mem_addr;
            last_err_pos  <= syn;
          end
`ifdef HAMMING_SECDED_EN
          if (do_uncorr) begin
            uncorr_cnt   <= sat_inc(uncorr_cnt);
            last_err_pos <= 3'd0;
          end
`endif
        end
        NEXT: begin
          if (state_d == RD) mem_addr <= mem_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Read data capture; pure datapath, no reset needed.
  always_ff @(posedge clk) begin
    if (state_q == RD && mem_ack) rdata_p0 <= mem_rdata;
  end

endmodule
